// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter feeding a single AND/OR/XOR unit with a held response channel.
// Define LOGIC_ARB_STATS_EN to add the saturating op_count output.
module logic_op_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_a,
  input  logic [WIDTH*NREQ-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err,
`ifdef LOGIC_ARB_STATS_EN
  output logic [15:0]              op_count,
`endif
  output logic                     busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic [NREQ-1:0]    req_ready_c;
  logic               grant_found_c;
  logic [IDW-1:0]     grant_id_c;
  logic [IDW-1:0]     cand_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_err_c;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]        op_count_q, op_count_d;
`endif

  logic [1:0]         op_arr [NREQ];
  logic [WIDTH-1:0]   a_arr  [NREQ];
  logic [WIDTH-1:0]   b_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[2*g +: 2];
    assign a_arr[g]  = req_a[WIDTH*g +: WIDTH];
    assign b_arr[g]  = req_b[WIDTH*g +: WIDTH];
  end

  // Search starts just after the last winner, so it gets lowest priority.
  always_comb begin
    grant_found_c = 1'b0;
    grant_id_c    = '0;
    cand_c        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_c = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!grant_found_c && req_valid[cand_c]) begin
        grant_found_c = 1'b1;
        grant_id_c    = cand_c;
      end
    end
  end

  always_comb begin
    alu_res_c = '0;
    alu_err_c = 1'b0;
    case (op_q)
      2'b00:   alu_res_c = a_q & b_q;
      2'b01:   alu_res_c = a_q | b_q;
      2'b10:   alu_res_c = a_q ^ b_q;
      default: alu_err_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    req_ready_c  = '0;
`ifdef LOGIC_ARB_STATS_EN
    op_count_d   = op_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found_c) begin
          // Strobe is masked while reset is held so nothing looks accepted.
          req_ready_c[grant_id_c] = rst_n;
          last_grant_d = grant_id_c;
          op_d         = op_arr[grant_id_c];
          a_d          = a_arr[grant_id_c];
          b_d          = b_arr[grant_id_c];
          rsp_id_d     = grant_id_c;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_res_c;
        rsp_err_d  = alu_err_c;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
`ifdef LOGIC_ARB_STATS_EN
          if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LOGIC_ARB_STATS_EN
      op_count_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
`ifdef LOGIC_ARB_STATS_EN
      op_count_q   <= op_count_d;
`endif
    end
  end

  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
`ifdef LOGIC_ARB_STATS_EN
  assign op_count  = op_count_q;
`endif

endmodule
